pattern_generator: RTL and testbench

Parametrised multi-mode test-pattern source for the VGA convolution pipeline. It replaces the fixed checkerboard source and drives the grayscale pixel stream consumed by the convolution stage. It is indexed by the VGA timing block's look-ahead coordinates (`x_next`, `y_next`) and its pixel-rate strobe (`output_tick`). Over the fixed source it adds:
- configurable patch size and pixel depth
- four runtime-selectable patterns, switched glitch-free at frame start
- blanking outside the active area
- optional per-frame horizontal scrolling

---
 rtl/pattern_generator.sv | 155 +++++++++++++++
 tb/tb_pattern_generator.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_generator.sv
// pattern_generator: multi-mode grayscale test-pattern source for the VGA
// convolution pipeline. Indexed by look-ahead coordinates (x_next, y_next)
// and advanced by the pixel strobe output_tick.
//
// Patterns (active_mode): 0 checkerboard, 1 horizontal ramp,
// 2 horizontal stripes, 3 flat white. Outside the active area the output
// is blanked to zero.
//
// Mode requests are captured into a pending register at any time and only
// take effect at frame start (output_tick with x_next == y_next == 0), so a
// frame never mixes patterns.
//
// Optional feature macro: PATGEN_SCROLL_EN. When defined, a per-frame
// horizontal scroll offset advances at each frame start while scroll_en is
// high. When undefined the offset is constant zero and scroll_en is ignored.
//
// Handshake note: mode_valid is a plain one-cycle strobe with no ready;
// every strobe is accepted and overwrites the pending request.
module pattern_generator #(
  parameter int COORD_W    = 10,
  parameter int PIX_W      = 4,
  parameter int PATCH_LOG2 = 6,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               output_tick,
  input  logic [COORD_W-1:0] x_next,
  input  logic [COORD_W-1:0] y_next,
  input  logic [1:0]         mode_req,
  input  logic               mode_valid,
  input  logic               scroll_en,
  output logic [PIX_W-1:0]   grayscale_color,
  output logic               frame_tick,
  output logic [1:0]         active_mode
);

  localparam logic [PIX_W-1:0] ALL_ONES     = '1;
  localparam logic [1:0]       MODE_CHECKER = 2'd0;
  localparam logic [1:0]       MODE_RAMP    = 2'd1;
  localparam logic [1:0]       MODE_STRIPES = 2'd2;
  localparam logic [1:0]       MODE_WHITE   = 2'd3;

  logic [1:0]         r_pending;
  logic [1:0]         r_active_mode;
  logic [PIX_W-1:0]   r_next_color;
  logic [PIX_W-1:0]   r_grayscale;
  logic               r_frame_tick;

  logic               w_fs;
  logic [1:0]         w_mode_eff;
  logic [COORD_W-1:0] w_offset_eff;
  logic [COORD_W-1:0] w_x_eff;
  logic               w_blank;
  logic [PIX_W-1:0]   w_pattern;
  logic               w_unused_x;

  assign w_fs = output_tick && (x_next == '0) && (y_next == '0);

  // Mode in effect for this cycle: a request in the FS cycle itself wins.
  always_comb begin
    w_mode_eff = r_active_mode;
    if (w_fs) begin
      w_mode_eff = mode_valid ? mode_req : r_pending;
    end
  end

`ifdef PATGEN_SCROLL_EN
  logic [COORD_W-1:0] r_offset;

  // Scroll offset for this cycle: advances by one at FS when enabled.
  always_comb begin
    w_offset_eff = r_offset;
    if (w_fs && scroll_en) begin
      w_offset_eff = r_offset + COORD_W'(1);
    end
  end

  // Offset register commits only at frame start; wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_offset <= '0;
    end else if (w_fs) begin
      r_offset <= w_offset_eff;
    end
  end
`else
  logic w_unused_scroll;

  assign w_offset_eff    = '0;
  assign w_unused_scroll = scroll_en;
`endif

  assign w_x_eff    = x_next + w_offset_eff;
  // Only a few bits of the shifted column select the pattern.
  assign w_unused_x = ^w_x_eff;

  // Blanking is decided on the raw column, never the scrolled one.
  assign w_blank = (int'(x_next) >= H_ACTIVE) || (int'(y_next) >= V_ACTIVE);

  // Pattern function on the effective column, raw row and effective mode.
  always_comb begin
    w_pattern = '0;
    if (!w_blank) begin
      case (w_mode_eff)
        MODE_CHECKER: w_pattern = (w_x_eff[PATCH_LOG2] ^ y_next[PATCH_LOG2]) ? '0 : ALL_ONES;
        MODE_RAMP:    w_pattern = w_x_eff[COORD_W-1 -: PIX_W];
        MODE_STRIPES: w_pattern = y_next[PATCH_LOG2] ? '0 : ALL_ONES;
        MODE_WHITE:   w_pattern = ALL_ONES;
        default:      w_pattern = '0;
      endcase
    end
  end

  // Pending request capture; last strobe in a frame wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= MODE_CHECKER;
    end else if (mode_valid) begin
      r_pending <= mode_req;
    end
  end

  // Active mode and frame pulse update only at frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_active_mode <= MODE_CHECKER;
      r_frame_tick  <= 1'b0;
    end else begin
      r_frame_tick <= w_fs;
      if (w_fs) begin
        r_active_mode <= w_mode_eff;
      end
    end
  end

  // Two-stage pixel pipeline: stage 1 every clock, stage 2 on the strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_next_color <= ALL_ONES;
      r_grayscale  <= ALL_ONES;
    end else begin
      r_next_color <= w_pattern;
      if (output_tick) begin
        r_grayscale <= r_next_color;
      end
    end
  end

  assign grayscale_color = r_grayscale;
  assign frame_tick      = r_frame_tick;
  assign active_mode     = r_active_mode;

endmodule

// File: tb/tb_pattern_generator.sv
// tb_pattern_generator: randomized and directed stimulus for
// pattern_generator, checked against a frame-level reference model.
// Define PATGEN_SCROLL_EN for both bench and RTL to cover scrolling.
module tb_pattern_generator;

  localparam int COORD_W    = 10;
  localparam int PIX_W      = 4;
  localparam int PATCH_LOG2 = 6;
  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int PATCH      = 1 << PATCH_LOG2;
  localparam int COORD_MOD  = 1 << COORD_W;
  localparam int WHITE      = (1 << PIX_W) - 1;
  localparam int RAMP_DIV   = 1 << (COORD_W - PIX_W);
`ifdef PATGEN_SCROLL_EN
  localparam bit SCROLL = 1'b1;
`else
  localparam bit SCROLL = 1'b0;
`endif

  // ---------------- clock / reset block ----------------
  logic               clk;
  logic               reset;
  logic               output_tick;
  logic [COORD_W-1:0] x_next;
  logic [COORD_W-1:0] y_next;
  logic [1:0]         mode_req;
  logic               mode_valid;
  logic               scroll_en;
  logic [PIX_W-1:0]   grayscale_color;
  logic               frame_tick;
  logic [1:0]         active_mode;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pattern_generator #(
    .COORD_W(COORD_W), .PIX_W(PIX_W), .PATCH_LOG2(PATCH_LOG2),
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)
  ) dut (
    .clk(clk), .reset(reset), .output_tick(output_tick),
    .x_next(x_next), .y_next(y_next), .mode_req(mode_req),
    .mode_valid(mode_valid), .scroll_en(scroll_en),
    .grayscale_color(grayscale_color), .frame_tick(frame_tick),
    .active_mode(active_mode)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [PIX_W-1:0] exp_q[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  int m_pending, m_active, m_offset, m_frame_tick;
  int m_gray;

  function automatic int ref_pixel(input int x, input int y, input int mode, input int off);
    int xe;
    if (x >= H_ACTIVE || y >= V_ACTIVE) return 0;
    xe = (x + off) % COORD_MOD;
    case (mode)
      0: return ((((xe / PATCH) + (y / PATCH)) % 2) == 0) ? WHITE : 0;
      1: return xe / RAMP_DIV;
      2: return (((y / PATCH) % 2) == 0) ? WHITE : 0;
      default: return WHITE;
    endcase
  endfunction

  // Applies one clock edge of the model. exp_q holds the single pixel
  // waiting between the two pipeline stages.
  task automatic model_edge(input bit rst, input bit tick, input int x, input int y,
                            input int mreq, input bit mv, input bit scr);
    bit fs;
    int mode_now, off_now;
    if (rst) begin
      m_pending = 0; m_active = 0; m_offset = 0; m_frame_tick = 0;
      m_gray = WHITE;
      exp_q.delete();
      exp_q.push_back(PIX_W'(WHITE));
      return;
    end
    fs       = tick && x == 0 && y == 0;
    mode_now = fs ? (mv ? mreq : m_pending) : m_active;
    off_now  = (fs && scr && SCROLL) ? (m_offset + 1) % COORD_MOD : m_offset;
    if (tick) m_gray = int'(exp_q[0]);
    exp_q.delete();
    exp_q.push_back(PIX_W'(ref_pixel(x, y, mode_now, off_now)));
    if (mv) m_pending = mreq;
    if (fs) begin
      m_active = mode_now;
      m_offset = off_now;
    end
    m_frame_tick = fs ? 1 : 0;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit rst, input bit tick, input int x, input int y,
                       input int mreq, input bit mv, input bit scr);
    reset       = rst;
    output_tick = tick;
    x_next      = COORD_W'(x);
    y_next      = COORD_W'(y);
    mode_req    = 2'(mreq);
    mode_valid  = mv;
    scroll_en   = scr;
    @(posedge clk);
    model_edge(rst, tick, x, y, mreq, mv, scr);
    #1;
    check("gray", int'(grayscale_color), m_gray);
    check("frame_tick", int'(frame_tick), m_frame_tick);
    check("active_mode", int'(active_mode), m_active);
  endtask

  task automatic px(input int x, input int y);
    drive(1'b0, 1'b1, x, y, 0, 1'b0, 1'b0);
  endtask

  task automatic request(input int x, input int y, input int m);
    drive(1'b0, 1'b1, x, y, m, 1'b1, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; output_tick = 1'b0; x_next = '0; y_next = '0;
    mode_req = '0; mode_valid = 1'b0; scroll_en = 1'b0;

    // Reset and checkerboard sweep along row 0.
    drive(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    check("reset_gray", int'(grayscale_color), WHITE);
    check("reset_mode", int'(active_mode), 0);
    check("reset_ft", int'(frame_tick), 0);
    for (int x = 0; x < H_ACTIVE; x++) begin
      px(x, 0);
      if (x == 64) check("sweep_x64", int'(grayscale_color), WHITE);
      if (x == 65) check("sweep_toggle", int'(grayscale_color), 0);
      if (x == 128) check("sweep_x128", int'(grayscale_color), 0);
      if (x == 129) check("sweep_return", int'(grayscale_color), WHITE);
    end

    // Mode switch at frame start.
    request(100, 5, 1);
    check("switch_hold", int'(active_mode), 0);
    px(200, 7);
    check("switch_hold2", int'(active_mode), 0);
    px(0, 0);
    check("switch_ft", int'(frame_tick), 1);
    check("switch_mode", int'(active_mode), 1);
    px(320, 0);
    check("ramp_x0", int'(grayscale_color), 0);
    check("ft_once", int'(frame_tick), 0);
    px(321, 0);
    check("ramp_x320", int'(grayscale_color), 320 / RAMP_DIV);

    // Simultaneous request: later request in the FS cycle wins.
    request(50, 60, 2);
    px(51, 60);
    request(0, 0, 3);
    check("simul_mode", int'(active_mode), 3);

    // Blanking in flat white.
    px(640, 10);
    px(5, 480);
    check("blank_x", int'(grayscale_color), 0);
    px(639, 479);
    check("blank_y", int'(grayscale_color), 0);
    px(10, 10);
    check("blank_corner", int'(grayscale_color), WHITE);

    // Back to checkerboard, then 64 scrolled frames.
    request(0, 0, 0);
    for (int f = 0; f < 64; f++) drive(1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b1);
    px(0, 0);
    px(1, 0);
    check("scroll_64", int'(grayscale_color), SCROLL ? 0 : WHITE);
    for (int f = 0; f < 1024 - 64; f++) drive(1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b1);
    px(63, 0);
    px(64, 0);
    check("scroll_wrap", int'(grayscale_color), WHITE);

    // Reset priority over FS with a pending request.
    for (int f = 0; f < 3; f++) drive(1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b1);
    request(30, 30, 2);
    drive(1'b1, 1'b1, 0, 0, 3, 1'b1, 1'b1);
    check("rst_prio_mode", int'(active_mode), 0);
    check("rst_prio_ft", int'(frame_tick), 0);
    px(0, 0);
    check("rst_prio_pending", int'(active_mode), 0);
    px(63, 0);
    px(64, 0);
    check("rst_prio_offset", int'(grayscale_color), WHITE);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      bit rst, tick, mv, scr;
      int x, y;
      rst  = ($urandom_range(0, 299) == 0);
      tick = ($urandom_range(0, 3) != 0);
      mv   = ($urandom_range(0, 9) == 0);
      scr  = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 7) == 0) begin
        x = 0; y = 0;
      end else begin
        x = $urandom_range(0, 799);
        y = $urandom_range(0, 524);
      end
      drive(rst, tick, x, y, $urandom_range(0, 3), mv, scr);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
